// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot pixel path.
//   ITER_W     : width of an iteration count
//   RGB_W      : width of a packed {r,g,b} pixel colour
//   MAP_LAT    : registered latency of the external colour mapper
//   PIX_ADDR_W : address width carried by pix_t (framebuffer address space)
//   arb_state_t: frame sequencer states
//   pix_t      : one coloured pixel on its way to the framebuffer
package mandel_pkg;

    localparam int ITER_W     = 32;
    localparam int RGB_W      = 24;
    localparam int MAP_LAT    = 1;
    localparam int PIX_ADDR_W = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [PIX_ADDR_W-1:0] addr;
        logic [RGB_W-1:0]      rgb;
    } pix_t;

endpackage

// File: rtl/pix_fifo.sv
// First-word-fall-through FIFO used to decouple a fixed-latency stream from
// a downstream consumer that can stall.
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push_i       : write push_data_i at the end of this cycle
//   pop_i        : consume the head this cycle (ignored while empty)
//   head_o       : current head, forced to zero while empty
//   valid_o      : FIFO holds at least one entry
//   count_o      : number of stored entries
// Push and pop in the same cycle are legal at any occupancy, including full.
module pix_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign valid_o = (cnt_q != '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & valid_o;
    // A pop frees the slot the simultaneous push lands in.
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = cnt_q;

    assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full && !pop_i));

endmodule

// File: rtl/mandel_pixel_arbiter.sv
// Shares one iteration-to-RGB colour mapper between NUM_ENG iteration
// engines and streams coloured pixels into the framebuffer, one frame per
// start pulse.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, max_iter_cfg   : frame start pulse (IDLE only), iteration limit
//   eng_valid/ready       : per-engine handshake, ready is a one-hot grant
//   eng_iter, eng_addr    : packed per-engine iteration count and address
//   map_iter/max_iter     : drive the external mapper (1-cycle registered)
//   map_r/g/b             : mapper colour output
//   fb_we/ready/addr/rgb  : framebuffer write port, pop = fb_we & fb_ready
//   busy, frame_done      : state != IDLE, one-cycle end-of-frame pulse
module mandel_pixel_arbiter
    import mandel_pkg::*;
#(
    parameter int NUM_ENG      = 4,
    parameter int ADDR_W       = 19,
    parameter int FRAME_PIXELS = 307200,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ITER_W-1:0]         max_iter_cfg,
    input  logic [NUM_ENG-1:0]        eng_valid,
    output logic [NUM_ENG-1:0]        eng_ready,
    input  logic [NUM_ENG*ITER_W-1:0] eng_iter,
    input  logic [NUM_ENG*ADDR_W-1:0] eng_addr,
    output logic [ITER_W-1:0]         map_iter,
    output logic [ITER_W-1:0]         map_max_iter,
    input  logic [7:0]                map_r,
    input  logic [7:0]                map_g,
    input  logic [7:0]                map_b,
    output logic                      fb_we,
    input  logic                      fb_ready,
    output logic [ADDR_W-1:0]         fb_addr,
    output logic [RGB_W-1:0]          fb_rgb,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int          RR_W        = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int          FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int          FIFO_W      = $bits(pix_t);
    localparam logic [31:0] FRAME_PIX_C = 32'(FRAME_PIXELS);
    localparam logic [31:0] DEPTH_C     = 32'(FIFO_DEPTH);

    // pix_t carries a fixed-width address; a wider framebuffer would truncate.
    if (ADDR_W != PIX_ADDR_W) begin : g_addr_w_check
        $error("ADDR_W must equal mandel_pkg::PIX_ADDR_W");
    end

    arb_state_t          state_q, state_d;
    logic [RR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [31:0]         issue_cnt_q, issue_cnt_d;
    logic [31:0]         write_cnt_q, write_cnt_d;
    logic [31:0]         occ_q, occ_d;
    logic [ITER_W-1:0]   map_iter_q;
    logic [ITER_W-1:0]   map_max_iter_q, map_max_iter_d;
    logic                vld_p1_q, vld_p2_q;
    logic [ADDR_W-1:0]   addr_p1_q, addr_p2_q;

    logic                start_acc;
    logic                grant_found;
    logic [RR_W-1:0]     grant_idx;
    logic [ITER_W-1:0]   sel_iter;
    logic [ADDR_W-1:0]   sel_addr;
    logic                hs;
    logic                pop;
    pix_t                push_pix, head_pix;
    logic [FIFO_W-1:0]   fifo_head;
    logic                fifo_valid;
    logic [FIFO_CNT_W-1:0] fifo_cnt;

    // Round-robin pick: first valid engine at or after rr_ptr, circularly.
    always_comb begin
        int unsigned cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            cand = 32'(rr_ptr_q) + 32'(k);
            if (cand >= 32'(NUM_ENG)) begin
                cand = cand - 32'(NUM_ENG);
            end
            if (!grant_found && eng_valid[cand[RR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[RR_W-1:0];
            end
        end
        sel_iter = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (grant_idx == RR_W'(i)) begin
                sel_iter = eng_iter[i*ITER_W +: ITER_W];
                sel_addr = eng_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign pop       = fifo_valid & fb_ready;
    assign start_acc = (state_q == IDLE) && start;

    // Credit check uses this cycle's pop so a draining FIFO keeps the grant
    // stream at one pixel per cycle.
    assign hs = (state_q == RUN) && (issue_cnt_q < FRAME_PIX_C) &&
                ((occ_q - 32'(pop)) < DEPTH_C) && grant_found;

    always_comb begin
        eng_ready = '0;
        if (hs) begin
            eng_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        issue_cnt_d    = start_acc ? '0 : issue_cnt_q + 32'(hs);
        write_cnt_d    = start_acc ? '0 : write_cnt_q + 32'(pop);
        occ_d          = occ_q + 32'(hs) - 32'(pop);
        map_max_iter_d = start_acc ? max_iter_cfg : map_max_iter_q;
        rr_ptr_d       = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (grant_idx == RR_W'(NUM_ENG - 1)) ? '0 : grant_idx + RR_W'(1);
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. DONE is entered in the cycle after the last pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (write_cnt_d == FRAME_PIX_C) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state_q != IDLE);
        frame_done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            issue_cnt_q    <= '0;
            write_cnt_q    <= '0;
            occ_q          <= '0;
            map_max_iter_q <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            issue_cnt_q    <= issue_cnt_d;
            write_cnt_q    <= write_cnt_d;
            occ_q          <= occ_d;
            map_max_iter_q <= map_max_iter_d;
        end
    end

    // Stage p1: granted iteration count presented to the mapper, address and
    // valid tag follow. Stage p2: the MAP_LAT delay matching the mapper register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_iter_q <= '0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
        end else begin
            if (hs) begin
                map_iter_q <= sel_iter;
            end
            vld_p1_q <= hs;
            vld_p2_q <= vld_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            addr_p1_q <= sel_addr;
        end
        addr_p2_q <= addr_p1_q;
    end

    // Stage p2 -> FIFO: mapper colour is valid now, joined with its address.
    always_comb begin
        push_pix.addr = PIX_ADDR_W'(addr_p2_q);
        push_pix.rgb  = {map_r, map_g, map_b};
        head_pix      = pix_t'(fifo_head);
    end

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W),
        .CNT_W (FIFO_CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (vld_p2_q),
        .push_data_i (push_pix),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_cnt)
    );

    assign fb_we        = fifo_valid;
    assign fb_addr      = ADDR_W'(head_pix.addr);
    assign fb_rgb       = head_pix.rgb;
    assign map_iter     = map_iter_q;
    assign map_max_iter = map_max_iter_q;

    // Stored pixels are always a subset of the credited ones.
    assert property (@(posedge clk) disable iff (!rst_n) 32'(fifo_cnt) <= occ_q);

endmodule

// File: tb/tb_mandel_pixel_arbiter.sv
`timescale 1ns/1ps
module tb_mandel_pixel_arbiter;

    localparam int NUM_ENG      = 4;
    localparam int ADDR_W       = 19;
    localparam int FRAME_PIXELS = 16;
    localparam int FIFO_DEPTH   = 4;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      start = 1'b0;
    logic [31:0]               max_iter_cfg = '0;
    logic [NUM_ENG-1:0]        eng_valid = '0;
    logic [NUM_ENG-1:0]        eng_ready;
    logic [NUM_ENG*32-1:0]     eng_iter;
    logic [NUM_ENG*ADDR_W-1:0] eng_addr;
    logic [31:0]               map_iter, map_max_iter;
    logic [7:0]                map_r, map_g, map_b;
    logic                      fb_we;
    logic                      fb_ready = 1'b0;
    logic [ADDR_W-1:0]         fb_addr;
    logic [23:0]               fb_rgb;
    logic                      busy, frame_done;

    logic [31:0]       it_a [NUM_ENG];
    logic [ADDR_W-1:0] ad_a [NUM_ENG];
    bit                acc  [NUM_ENG];

    for (genvar g = 0; g < NUM_ENG; g++) begin : g_pack
        assign eng_iter[g*32 +: 32]         = it_a[g];
        assign eng_addr[g*ADDR_W +: ADDR_W] = ad_a[g];
    end

    mandel_pixel_arbiter #(
        .NUM_ENG      (NUM_ENG),
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FRAME_PIXELS),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .max_iter_cfg (max_iter_cfg),
        .eng_valid    (eng_valid),
        .eng_ready    (eng_ready),
        .eng_iter     (eng_iter),
        .eng_addr     (eng_addr),
        .map_iter     (map_iter),
        .map_max_iter (map_max_iter),
        .map_r        (map_r),
        .map_g        (map_g),
        .map_b        (map_b),
        .fb_we        (fb_we),
        .fb_ready     (fb_ready),
        .fb_addr      (fb_addr),
        .fb_rgb       (fb_rgb),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Colour mapper stand-in: one registered stage.
    function automatic logic [23:0] cmap(input logic [31:0] it, input logic [31:0] mx);
        if (it >= mx) return 24'h000000;
        return {it[7:0], it[10:3] ^ 8'hA5, mx[7:0] - it[7:0]};
    endfunction

    always @(posedge clk) {map_r, map_g, map_b} <= cmap(map_iter, map_max_iter);

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and per-frame statistics
    logic [42:0] exp_q[$];
    int          hs_cyc_q[$];
    logic [31:0] cur_max = '0;
    int cyc = 0;
    int f_hs, f_pop, f_done;
    int first_hs_cyc, last_hs_cyc, first_pop_cyc, last_pop_cyc, done_cyc;
    int first_grant, first_lat;
    int last_g = NUM_ENG - 1;
    bit fair_mode = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            chk("ready_subset", 64'(eng_ready & ~eng_valid), 64'(0));
            chk("ready_onehot", 64'($countones(eng_ready) <= 1), 64'(1));
            for (int i = 0; i < NUM_ENG; i++) begin
                if (eng_valid[i] && eng_ready[i]) begin
                    if (fair_mode) chk("rr_order", 64'(i), 64'((last_g + 1) % NUM_ENG));
                    last_g = i;
                    acc[i] = 1'b1;
                    if (f_hs == 0) begin
                        first_hs_cyc = cyc;
                        first_grant  = i;
                    end
                    last_hs_cyc = cyc;
                    f_hs++;
                    exp_q.push_back({ad_a[i], cmap(it_a[i], cur_max)});
                    hs_cyc_q.push_back(cyc);
                end
            end
            if (fb_we && fb_ready) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    logic [42:0] e;
                    int hc;
                    e  = exp_q.pop_front();
                    hc = hs_cyc_q.pop_front();
                    chk("fb_pixel", 64'({fb_addr, fb_rgb}), 64'(e));
                    chk("lat_min", 64'(cyc - hc >= 3), 64'(1));
                    if (f_pop == 0) begin
                        first_pop_cyc = cyc;
                        first_lat     = cyc - hc;
                    end
                end
                f_pop++;
                last_pop_cyc = cyc;
            end
            if (frame_done) begin
                f_done++;
                done_cyc = cyc;
            end
        end
    end

    logic [NUM_ENG-1:0] en_mask = '0;
    bit rand_v = 1'b0, rand_fb = 1'b0, fb_hold = 1'b0;
    int next_addr = 100;

    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (acc[i]) begin
                acc[i]  = 1'b0;
                it_a[i] = 32'($urandom_range(0, 1500));
                ad_a[i] = ADDR_W'(next_addr);
                next_addr++;
            end
            eng_valid[i] = en_mask[i] && (!rand_v || ($urandom_range(0, 3) != 0));
        end
        fb_ready = fb_hold ? 1'b0 : (!rand_fb || ($urandom_range(0, 2) != 0));
    endtask

    task automatic start_frame(input logic [31:0] mx);
        f_hs = 0; f_pop = 0; f_done = 0;
        cur_max      = mx;
        max_iter_cfg = mx;
        start        = 1'b1;
        step();
        chk("max_latched", 64'(map_max_iter), 64'(mx));
        chk("busy_run", 64'(busy), 64'(1));
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (f_done == 0 && n < budget) begin
            step();
            n++;
        end
        chk("frame_done_seen", 64'(f_done != 0), 64'(1));
        step();
        step();
    endtask

    task automatic frame_checks();
        chk("frame_hs", 64'(f_hs), 64'(FRAME_PIXELS));
        chk("frame_pop", 64'(f_pop), 64'(FRAME_PIXELS));
        chk("done_once", 64'(f_done), 64'(1));
        chk("done_timing", 64'(done_cyc), 64'(last_pop_cyc + 1));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("sb_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [42:0] head0;
        int n;
        for (int i = 0; i < NUM_ENG; i++) begin
            it_a[i] = 32'(10 * i + 7);
            ad_a[i] = ADDR_W'(50 + i);
            acc[i]  = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(eng_ready), 64'(0));
        chk("rst_map_iter", 64'(map_iter), 64'(0));
        chk("rst_map_max", 64'(map_max_iter), 64'(0));
        chk("rst_fb_we", 64'(fb_we), 64'(0));
        chk("rst_fb_addr", 64'(fb_addr), 64'(0));
        chk("rst_fb_rgb", 64'(fb_rgb), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(frame_done), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle: every engine valid, no start
        en_mask = '1;
        fb_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("idle_ready", 64'(eng_ready), 64'(0));
            chk("idle_fb_we", 64'(fb_we), 64'(0));
            chk("idle_busy", 64'(busy), 64'(0));
        end

        // Single engine: engine 2 only, first pixel iter=300 addr=5
        en_mask = 4'b0100;
        it_a[2] = 32'd300;
        ad_a[2] = ADDR_W'(5);
        step();
        start_frame(32'd1000);
        wait_done(200);
        chk("single_grant", 64'(first_grant), 64'(2));
        chk("single_latency", 64'(first_lat), 64'(3));
        frame_checks();

        // Fairness: all valid, no backpressure
        en_mask   = '1;
        fair_mode = 1'b1;
        start_frame(32'd500);
        wait_done(200);
        fair_mode = 1'b0;
        chk("fair_hs_burst", 64'(last_hs_cyc - first_hs_cyc), 64'(FRAME_PIXELS - 1));
        chk("fair_pop_burst", 64'(last_pop_cyc - first_pop_cyc), 64'(FRAME_PIXELS - 1));
        chk("fair_first_lat", 64'(first_pop_cyc - first_hs_cyc), 64'(3));
        frame_checks();

        // Backpressure: framebuffer stalled for 20 cycles
        fb_hold = 1'b1;
        start_frame(32'd800);
        repeat (10) step();
        head0 = {fb_addr, fb_rgb};
        chk("bp_we", 64'(fb_we), 64'(1));
        repeat (10) step();
        chk("bp_accepted", 64'(f_hs > 0 && f_hs <= FIFO_DEPTH), 64'(1));
        chk("bp_ready_low", 64'(eng_ready), 64'(0));
        chk("bp_head_stable", 64'({fb_addr, fb_rgb}), 64'(head0));
        chk("bp_no_pop", 64'(f_pop), 64'(0));
        fb_hold = 1'b0;
        wait_done(200);
        frame_checks();

        // Random valid / fb_ready, with an ignored start in RUN
        rand_v  = 1'b1;
        rand_fb = 1'b1;
        start_frame(32'd1200);
        repeat (5) step();
        start        = 1'b1;
        max_iter_cfg = 32'd7;
        step();
        chk("restart_busy", 64'(busy), 64'(1));
        chk("restart_max", 64'(map_max_iter), 64'(1200));
        wait_done(600);
        frame_checks();
        rand_v  = 1'b0;
        rand_fb = 1'b0;

        // Reset with pixels in flight
        start_frame(32'd900);
        n = 0;
        while (f_hs < 3 && n < 20) begin
            step();
            n++;
        end
        chk("pre_reset_hs", 64'(f_hs >= 3), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(eng_ready), 64'(0));
        chk("mid_rst_fb_we", 64'(fb_we), 64'(0));
        chk("mid_rst_fb_addr", 64'(fb_addr), 64'(0));
        chk("mid_rst_fb_rgb", 64'(fb_rgb), 64'(0));
        chk("mid_rst_map_iter", 64'(map_iter), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        exp_q.delete();
        hs_cyc_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("post_rst_fb_we", 64'(fb_we), 64'(0));
            chk("post_rst_busy", 64'(busy), 64'(0));
        end
        start_frame(32'd1000);
        wait_done(200);
        frame_checks();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
